// File: rtl/writeback_stage_if.sv
// MEM/WB bus of the writeback stage: MEM-side capture inputs and the
// register-file write port, bypass slot and retired counter it drives.
interface writeback_stage_if #(
   parameter int CNT_W = 16
);
   logic             mem_valid;
   logic             mem_reg_write;
   logic [4:0]       mem_rd;
   logic [1:0]       mem_wb_sel;
   logic [7:0]       mem_alu_result;
   logic [7:0]       mem_read_data;
   logic [7:0]       mem_link_addr;
   logic             flush;
   logic             reg_write;
   logic [4:0]       write_reg;
   logic [7:0]       write_reg_data;
   logic             prev_valid;
   logic [4:0]       prev_rd;
   logic [7:0]       prev_data;
   logic [CNT_W-1:0] retired_count;

   modport master (
      output mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
             mem_alu_result, mem_read_data, mem_link_addr, flush,
      input  reg_write, write_reg, write_reg_data,
             prev_valid, prev_rd, prev_data, retired_count
   );

   modport slave (
      input  mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
             mem_alu_result, mem_read_data, mem_link_addr, flush,
      output reg_write, write_reg, write_reg_data,
             prev_valid, prev_rd, prev_data, retired_count
   );
endinterface

// File: rtl/writeback_stage.sv
// WB stage of the 8-bit RISC-V pipeline: captures the MEM/WB entry, drives the
// register-file write port, keeps a previous-commit bypass slot and a retire counter.
module writeback_stage #(
   parameter int CNT_W = 16
) (
   input logic               clock,
   input logic               reset,
   writeback_stage_if.slave  wb
);
   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;

   logic             capture_s;
   logic             reg_write_d,      reg_write_q;
   logic [4:0]       write_reg_d,      write_reg_q;
   logic [7:0]       write_reg_data_d, write_reg_data_q;
   logic             prev_valid_d,     prev_valid_q;
   logic [4:0]       prev_rd_d,        prev_rd_q;
   logic [7:0]       prev_data_d,      prev_data_q;
   logic [CNT_W-1:0] retired_count_d,  retired_count_q;

   // Reserved select (11) yields zero data; it never writes anyway.
   function automatic logic [7:0] select_result(
      input logic [1:0] sel,
      input logic [7:0] alu,
      input logic [7:0] load,
      input logic [7:0] link
   );
      logic [7:0] res;
      case (sel)
         SEL_ALU:  res = alu;
         SEL_LOAD: res = load;
         SEL_LINK: res = link;
         default:  res = 8'h00;
      endcase
      return res;
   endfunction

   assign capture_s = wb.mem_valid & ~wb.flush;

   // Next-state for the WB entry, bypass slot and retire counter.
   always_comb begin
      reg_write_d      = 1'b0;
      write_reg_d      = write_reg_q;
      write_reg_data_d = write_reg_data_q;
      retired_count_d  = retired_count_q;
      if (capture_s) begin
         write_reg_d      = wb.mem_rd;
         write_reg_data_d = select_result(wb.mem_wb_sel, wb.mem_alu_result,
                                          wb.mem_read_data, wb.mem_link_addr);
         reg_write_d      = wb.mem_reg_write & (wb.mem_rd != 5'd0)
                            & (wb.mem_wb_sel != 2'b11);
         retired_count_d  = retired_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         reg_write_d      = 1'b0;
      end
      prev_valid_d = reg_write_q;
      prev_rd_d    = write_reg_q;
      prev_data_d  = write_reg_data_q;
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         reg_write_q      <= 1'b0;
         write_reg_q      <= 5'd0;
         write_reg_data_q <= 8'h00;
         prev_valid_q     <= 1'b0;
         prev_rd_q        <= 5'd0;
         prev_data_q      <= 8'h00;
         retired_count_q  <= '0;
      end else begin
         reg_write_q      <= reg_write_d;
         write_reg_q      <= write_reg_d;
         write_reg_data_q <= write_reg_data_d;
         prev_valid_q     <= prev_valid_d;
         prev_rd_q        <= prev_rd_d;
         prev_data_q      <= prev_data_d;
         retired_count_q  <= retired_count_d;
      end
   end

   assign wb.reg_write      = reg_write_q;
   assign wb.write_reg      = write_reg_q;
   assign wb.write_reg_data = write_reg_data_q;
   assign wb.prev_valid     = prev_valid_q;
   assign wb.prev_rd        = prev_rd_q;
   assign wb.prev_data      = prev_data_q;
   assign wb.retired_count  = retired_count_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus random
// traffic compared against a commit-level reference model.
module tb_writeback_stage;
   localparam int CNT_W = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   writeback_stage_if #(.CNT_W(CNT_W)) wb ();
   writeback_stage #(.CNT_W(CNT_W)) dut (.clock(clock), .reset(reset), .wb(wb));

   always #5 clock = ~clock;

   // Reference model: the committed write and the one before it, plus a retire tally.
   logic             m_we, m_pv;
   logic [4:0]       m_rd, m_prd;
   logic [7:0]       m_data, m_pdata;
   bit               m_data_known, m_pdata_known;
   logic [CNT_W-1:0] m_cnt;

   task automatic cycle(input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [7:0] alu,
                        input logic [7:0] rdata, input logic [7:0] link,
                        input logic fl, input logic rst);
      wb.mem_valid = v; wb.mem_reg_write = rw; wb.mem_rd = rd; wb.mem_wb_sel = sel;
      wb.mem_alu_result = alu; wb.mem_read_data = rdata; wb.mem_link_addr = link;
      wb.flush = fl; reset = rst;
      @(posedge clock);
      #1;
      if (rst) begin
         m_we = 1'b0; m_rd = 5'd0; m_data = 8'h00; m_data_known = 1'b1;
         m_pv = 1'b0; m_prd = 5'd0; m_pdata = 8'h00; m_pdata_known = 1'b1;
         m_cnt = '0;
      end else begin
         m_pv = m_we; m_prd = m_rd; m_pdata = m_data; m_pdata_known = m_data_known;
         if (v && !fl) begin
            m_cnt = m_cnt + 1'b1;
            m_rd  = rd;
            m_we  = rw && (rd != 5'd0) && (sel != 2'b11);
            m_data_known = 1'b1;
            if (sel == 2'b00) m_data = alu;
            else if (sel == 2'b01) m_data = rdata;
            else if (sel == 2'b10) m_data = link;
            else m_data_known = 1'b0;
         end else begin
            m_we = 1'b0;
         end
      end
   endtask

   task automatic bubble();
      cycle(1'b0, 1'b0, 5'd0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      cycle(1'b0, 1'b0, 5'd0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (wb.reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write got %b exp 0", wb.reg_write); end
      n_checks++; if (wb.write_reg !== 5'd0) begin n_fail++; $display("FAIL reset_write_reg got %0d exp 0", wb.write_reg); end
      n_checks++; if (wb.write_reg_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", wb.write_reg_data); end
      n_checks++; if (wb.prev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_prev_valid got %b exp 0", wb.prev_valid); end
      n_checks++; if (wb.prev_rd !== 5'd0 || wb.prev_data !== 8'h00) begin n_fail++; $display("FAIL reset_prev got %0d/%h exp 0/00", wb.prev_rd, wb.prev_data); end
      n_checks++; if (wb.retired_count !== 16'h0000) begin n_fail++; $display("FAIL reset_count got %h exp 0000", wb.retired_count); end
   endtask

   task automatic test_alu_write();
      do_reset();
      cycle(1'b1, 1'b1, 5'd5, 2'b00, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0);
      n_checks++; if (wb.reg_write !== 1'b1 || wb.write_reg !== 5'd5 || wb.write_reg_data !== 8'h3C) begin
         n_fail++; $display("FAIL alu_commit got %b/%0d/%h exp 1/5/3c", wb.reg_write, wb.write_reg, wb.write_reg_data); end
      bubble();
      n_checks++; if (wb.prev_valid !== 1'b1 || wb.prev_rd !== 5'd5 || wb.prev_data !== 8'h3C) begin
         n_fail++; $display("FAIL alu_prev got %b/%0d/%h exp 1/5/3c", wb.prev_valid, wb.prev_rd, wb.prev_data); end
      n_checks++; if (wb.retired_count !== 16'd1) begin n_fail++; $display("FAIL alu_count got %0d exp 1", wb.retired_count); end
      n_checks++; if (wb.reg_write !== 1'b0) begin n_fail++; $display("FAIL alu_bubble got %b exp 0", wb.reg_write); end
   endtask

   task automatic test_mux();
      do_reset();
      cycle(1'b1, 1'b1, 5'd3, 2'b01, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0);
      n_checks++; if (wb.reg_write !== 1'b1 || wb.write_reg_data !== 8'hA5) begin n_fail++; $display("FAIL mux_load got %b/%h exp 1/a5", wb.reg_write, wb.write_reg_data); end
      cycle(1'b1, 1'b1, 5'd1, 2'b10, 8'h00, 8'h00, 8'h14, 1'b0, 1'b0);
      n_checks++; if (wb.reg_write !== 1'b1 || wb.write_reg_data !== 8'h14) begin n_fail++; $display("FAIL mux_link got %b/%h exp 1/14", wb.reg_write, wb.write_reg_data); end
      cycle(1'b1, 1'b1, 5'd2, 2'b11, 8'h77, 8'h88, 8'h99, 1'b0, 1'b0);
      n_checks++; if (wb.reg_write !== 1'b0) begin n_fail++; $display("FAIL mux_reserved_we got %b exp 0", wb.reg_write); end
      n_checks++; if (wb.retired_count !== 16'd3) begin n_fail++; $display("FAIL mux_reserved_count got %0d exp 3", wb.retired_count); end
   endtask

   task automatic test_x0();
      do_reset();
      cycle(1'b1, 1'b1, 5'd0, 2'b00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
      n_checks++; if (wb.reg_write !== 1'b0) begin n_fail++; $display("FAIL x0_we got %b exp 0", wb.reg_write); end
      n_checks++; if (wb.retired_count !== 16'd1) begin n_fail++; $display("FAIL x0_count got %0d exp 1", wb.retired_count); end
      bubble();
      n_checks++; if (wb.prev_valid !== 1'b0) begin n_fail++; $display("FAIL x0_prev got %b exp 0", wb.prev_valid); end
   endtask

   task automatic test_flush_bubble();
      do_reset();
      cycle(1'b1, 1'b1, 5'd9, 2'b00, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 5'd3, 2'b00, 8'h77, 8'h00, 8'h00, 1'b1, 1'b0);
      n_checks++; if (wb.reg_write !== 1'b0 || wb.retired_count !== 16'd1) begin n_fail++; $display("FAIL flush got we=%b cnt=%0d exp 0/1", wb.reg_write, wb.retired_count); end
      n_checks++; if (wb.prev_valid !== 1'b1 || wb.prev_data !== 8'h5A) begin n_fail++; $display("FAIL flush_prev got %b/%h exp 1/5a", wb.prev_valid, wb.prev_data); end
      cycle(1'b0, 1'b1, 5'd4, 2'b00, 8'h66, 8'h00, 8'h00, 1'b0, 1'b0);
      n_checks++; if (wb.reg_write !== 1'b0 || wb.write_reg !== 5'd9 || wb.write_reg_data !== 8'h5A) begin
         n_fail++; $display("FAIL bubble_hold got %b/%0d/%h exp 0/9/5a", wb.reg_write, wb.write_reg, wb.write_reg_data); end
      n_checks++; if (wb.retired_count !== 16'd1) begin n_fail++; $display("FAIL bubble_count got %0d exp 1", wb.retired_count); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      cycle(1'b1, 1'b1, 5'd7, 2'b00, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 5'd7, 2'b00, 8'h22, 8'h00, 8'h00, 1'b0, 1'b0);
      n_checks++; if (wb.write_reg_data !== 8'h22 || wb.write_reg !== 5'd7 || wb.reg_write !== 1'b1) begin
         n_fail++; $display("FAIL b2b_cur got %b/%0d/%h exp 1/7/22", wb.reg_write, wb.write_reg, wb.write_reg_data); end
      n_checks++; if (wb.prev_data !== 8'h11 || wb.prev_rd !== 5'd7 || wb.prev_valid !== 1'b1) begin
         n_fail++; $display("FAIL b2b_prev got %b/%0d/%h exp 1/7/11", wb.prev_valid, wb.prev_rd, wb.prev_data); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
               2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
         n_checks++; if (wb.reg_write !== m_we || wb.write_reg !== m_rd) begin
            n_fail++; $display("FAIL rnd_cur[%0d] got %b/%0d exp %b/%0d", i, wb.reg_write, wb.write_reg, m_we, m_rd); end
         if (m_data_known) begin
            n_checks++; if (wb.write_reg_data !== m_data) begin n_fail++; $display("FAIL rnd_data[%0d] got %h exp %h", i, wb.write_reg_data, m_data); end
         end
         n_checks++; if (wb.prev_valid !== m_pv || wb.prev_rd !== m_prd) begin
            n_fail++; $display("FAIL rnd_prev[%0d] got %b/%0d exp %b/%0d", i, wb.prev_valid, wb.prev_rd, m_pv, m_prd); end
         if (m_pdata_known) begin
            n_checks++; if (wb.prev_data !== m_pdata) begin n_fail++; $display("FAIL rnd_pdata[%0d] got %h exp %h", i, wb.prev_data, m_pdata); end
         end
         n_checks++; if (wb.retired_count !== m_cnt) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, wb.retired_count, m_cnt); end
      end
   endtask

   task automatic test_midstream_reset();
      do_reset();
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 1'b1, 5'(i + 1), 2'b00, 8'(8'h40 + i), 8'h00, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 5'd12, 2'b00, 8'hEE, 8'h00, 8'h00, 1'b0, 1'b1);
      n_checks++; if (wb.reg_write !== 1'b0 || wb.write_reg !== 5'd0 || wb.write_reg_data !== 8'h00) begin
         n_fail++; $display("FAIL mid_reset_cur got %b/%0d/%h exp 0/0/00", wb.reg_write, wb.write_reg, wb.write_reg_data); end
      n_checks++; if (wb.prev_valid !== 1'b0 || wb.prev_rd !== 5'd0 || wb.prev_data !== 8'h00 || wb.retired_count !== 16'd0) begin
         n_fail++; $display("FAIL mid_reset_prev got %b/%0d/%h cnt=%0d exp 0/0/00 cnt=0", wb.prev_valid, wb.prev_rd, wb.prev_data, wb.retired_count); end
      cycle(1'b1, 1'b1, 5'd13, 2'b00, 8'hC3, 8'h00, 8'h00, 1'b0, 1'b0);
      n_checks++; if (wb.reg_write !== 1'b1 || wb.write_reg_data !== 8'hC3 || wb.retired_count !== 16'd1) begin
         n_fail++; $display("FAIL post_reset_capture got %b/%h cnt=%0d exp 1/c3 cnt=1", wb.reg_write, wb.write_reg_data, wb.retired_count); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 65535; i++)
         cycle(1'b1, $urandom_range(0, 1), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
               8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
      n_checks++; if (wb.retired_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_full got %h exp ffff", wb.retired_count); end
      cycle(1'b1, 1'b1, 5'd6, 2'b00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
      n_checks++; if (wb.retired_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h exp 0000", wb.retired_count); end
   endtask

   initial begin
      test_reset();
      test_alu_write();
      test_mux();
      test_x0();
      test_flush_bubble();
      test_back_to_back();
      test_random();
      test_midstream_reset();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
